// File: rtl/dm_jtag_pkg.sv
// Shared TAP state encoding, default opcodes and the IR capture pattern.
// No latency or backpressure: declarations only.
package dm_jtag_pkg;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [4:0]  DEF_IR_IDCODE = 5'h01;
    localparam logic [4:0]  DEF_IR_DTMCS  = 5'h10;
    localparam logic [4:0]  DEF_IR_DMI    = 5'h11;
    localparam logic [31:0] DEF_IDCODE    = 32'h0000_0DB3;

    // Zero-extended to IR_LEN at the point of use.
    localparam logic [1:0]  IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/dmi_jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: TMS sampled on rising tck_i, state registered.
// One tck of latency from TMS to state; no backpressure (JTAG is host-paced).
module dmi_jtag_tap_fsm
    import dm_jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       tms_i,
    output tap_state_e state
);

    tap_state_e state_d;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state <= TLR;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            TLR:     state_d = tms_i ? TLR    : RTI;
            RTI:     state_d = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:   state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:   state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

endmodule

// File: rtl/dmi_jtag_soft_tap.sv
// Pin-level JTAG TAP with IR, IDCODE and BYPASS registers driving the DTM strobes.
// Strobes are combinational on state; TDO lags by half a tck; no backpressure.
module dmi_jtag_soft_tap
    import dm_jtag_pkg::*;
#(
    parameter int unsigned       IR_LEN     = 5,
    parameter logic [31:0]       IDCODE_VAL = DEF_IDCODE,
    parameter logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(DEF_IR_IDCODE),
    parameter logic [IR_LEN-1:0] IR_DTMCS   = IR_LEN'(DEF_IR_DTMCS),
    parameter logic [IR_LEN-1:0] IR_DMI     = IR_LEN'(DEF_IR_DMI)
) (
    input  logic tck_i,
    input  logic trst_ni,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic tdi_o,
    output logic capture_o,
    output logic shift_o,
    output logic update_o,
    output logic dmi_clear_o,
    output logic dtmcs_select_o,
    input  logic dtmcs_tdo_i,
    output logic dmi_select_o,
    input  logic dmi_tdo_i
);

    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("IDCODE_VAL bit 0 must be 1");
    end
    if (IR_LEN < 2) begin : g_bad_ir_len
        $error("IR_LEN must be at least 2");
    end

    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(IR_CAPTURE_LSBS);

    tap_state_e        state;
    logic [IR_LEN-1:0] ir_q;
    logic [IR_LEN-1:0] ir_shift;
    logic [31:0]       idcode_q;
    logic              bypass_q;
    logic              sel_idcode;
    logic              sel_bypass;
    logic              dr_tdo;

    dmi_jtag_tap_fsm u_fsm (
        .tck_i   (tck_i),
        .trst_ni (trst_ni),
        .tms_i   (tms_i),
        .state   (state)
    );

    assign sel_idcode     = (ir_q == IR_IDCODE);
    assign dtmcs_select_o = (ir_q == IR_DTMCS);
    assign dmi_select_o   = (ir_q == IR_DMI);
    assign sel_bypass     = !sel_idcode && !dtmcs_select_o && !dmi_select_o;

    assign capture_o   = (state == CAP_DR);
    assign shift_o     = (state == SH_DR);
    assign update_o    = (state == UPD_DR);
    assign dmi_clear_o = (state == TLR);
    assign tdi_o       = tdi_i;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir_q     <= IR_IDCODE;
            ir_shift <= IR_CAPTURE;
            idcode_q <= IDCODE_VAL;
            bypass_q <= 1'b0;
        end else begin
            case (state)
                TLR:    ir_q     <= IR_IDCODE;
                CAP_IR: ir_shift <= IR_CAPTURE;
                SH_IR:  ir_shift <= {tdi_i, ir_shift[IR_LEN-1:1]};
                UPD_IR: ir_q     <= ir_shift;
                CAP_DR: begin
                    if (sel_idcode) idcode_q <= IDCODE_VAL;
                    if (sel_bypass) bypass_q <= 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode) idcode_q <= {tdi_i, idcode_q[31:1]};
                    if (sel_bypass) bypass_q <= tdi_i;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dr_tdo = bypass_q;
        if (sel_idcode) begin
            dr_tdo = idcode_q[0];
        end else if (dtmcs_select_o) begin
            dr_tdo = dtmcs_tdo_i;
        end else if (dmi_select_o) begin
            dr_tdo = dmi_tdo_i;
        end
    end

    // Falling-edge launch gives the host a full half period of setup before it samples.
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tdo_o    <= 1'b0;
            tdo_oe_o <= 1'b0;
        end else begin
            case (state)
                SH_IR: begin
                    tdo_o    <= ir_shift[0];
                    tdo_oe_o <= 1'b1;
                end
                SH_DR: begin
                    tdo_o    <= dr_tdo;
                    tdo_oe_o <= 1'b1;
                end
                default: tdo_oe_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_jtag_soft_tap.sv
// Directed scans with a TDO scoreboard, plus a random TMS walk against a reference state table.
module tb_dmi_jtag_soft_tap;
    import dm_jtag_pkg::*;

    logic tck_i = 1'b0;
    logic trst_ni, tms_i, tdi_i, dtmcs_tdo_i, dmi_tdo_i;
    logic tdo_o, tdo_oe_o, tdi_o, capture_o, shift_o, update_o, dmi_clear_o;
    logic dtmcs_select_o, dmi_select_o;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    logic mon_en = 1'b1;
    logic mon_has, mon_exp;
    tap_state_e model;

    dmi_jtag_soft_tap dut (
        .tck_i          (tck_i),
        .trst_ni        (trst_ni),
        .tms_i          (tms_i),
        .tdi_i          (tdi_i),
        .tdo_o          (tdo_o),
        .tdo_oe_o       (tdo_oe_o),
        .tdi_o          (tdi_o),
        .capture_o      (capture_o),
        .shift_o        (shift_o),
        .update_o       (update_o),
        .dmi_clear_o    (dmi_clear_o),
        .dtmcs_select_o (dtmcs_select_o),
        .dtmcs_tdo_i    (dtmcs_tdo_i),
        .dmi_select_o   (dmi_select_o),
        .dmi_tdo_i      (dmi_tdo_i)
    );

    always #5 tck_i = ~tck_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every driven TDO bit must match the next queued expectation.
    always @(negedge tck_i) begin
        #1;
        mon_has = (exp_q.size() != 0);
        if (mon_en && (tdo_oe_o || mon_has)) begin
            chk("tdo_oe", 32'(tdo_oe_o), 32'(mon_has));
            if (mon_has) begin
                mon_exp = exp_q.pop_front();
                if (tdo_oe_o) chk("tdo", 32'(tdo_o), 32'(mon_exp));
            end
        end
    end

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PA_DR;
            PA_DR:   return tms ? EX2_DR : PA_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PA_IR;
            PA_IR:   return tms ? EX2_IR : PA_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            default: return tms ? SEL_DR : RTI;
        endcase
    endfunction

    task automatic tick(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        #2;
    endtask

    // From RTI; leaves the TAP in UPD_IR so the caller can see the select switch a cycle later.
    task automatic scan_ir(input logic [4:0] tdi, input logic [4:0] exp);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp[i]);
            tick(i == 4, tdi[i]);
        end
        tick(1, 0);
    endtask

    // From RTI back to RTI; exp/dmi bits are LSB-first.
    task automatic scan_dr(input int n, input logic [31:0] tdi, input logic [31:0] exp,
                           input logic [31:0] dmi);
        tick(1, 0);
        tick(0, 0);
        chk("capture_pulse", 32'({capture_o, shift_o}), 32'b10);
        tick(0, 0);
        for (int i = 0; i < n; i++) begin
            chk("shift_hold", 32'({capture_o, shift_o, update_o}), 32'b010);
            dmi_tdo_i = dmi[i];
            exp_q.push_back(exp[i]);
            tick(i == n - 1, tdi[i]);
        end
        chk("shift_end", 32'(shift_o), 32'(0));
        tick(1, 0);
        chk("update_pulse", 32'(update_o), 32'(1));
        tick(0, 0);
        chk("update_end", 32'(update_o), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        trst_ni = 1'b0; tms_i = 1'b1; tdi_i = 1'b0;
        dtmcs_tdo_i = 1'b0; dmi_tdo_i = 1'b0;
        @(posedge tck_i); #2;
        chk("rst_tdo", 32'({tdo_o, tdo_oe_o}), 32'b00);
        chk("rst_clear", 32'(dmi_clear_o), 32'(1));
        chk("rst_strobes", 32'({capture_o, shift_o, update_o}), 32'b000);
        chk("rst_selects", 32'({dtmcs_select_o, dmi_select_o}), 32'b00);
        trst_ni = 1'b1;
        tick(0, 0);
        chk("rti_clear", 32'(dmi_clear_o), 32'(0));

        scan_dr(32, 32'h0, 32'h0000_0DB3, 32'h0);

        scan_ir(5'h11, 5'b00001);
        chk("dmi_sel_in_upd_ir", 32'(dmi_select_o), 32'(0));
        tick(0, 0);
        chk("dmi_sel_after_upd", 32'({dmi_select_o, dtmcs_select_o}), 32'b10);
        scan_dr(8, 32'hA5, 32'h3C, 32'h3C);

        tick(1, 0); tick(0, 0); tick(0, 0);
        dmi_tdo_i = 1'b1;
        exp_q.push_back(1'b1);
        for (int i = 0; i < 6; i++) tick(1, 0);
        chk("tlr_clear", 32'(dmi_clear_o), 32'(1));
        chk("tlr_ir_reload", 32'({dmi_select_o, dtmcs_select_o}), 32'b00);
        tick(0, 0);
        scan_dr(32, 32'hFFFF_FFFF, 32'h0000_0DB3, 32'h0);

        scan_ir(5'h1F, 5'b00001);
        tick(0, 0);
        chk("bypass_selects", 32'({dmi_select_o, dtmcs_select_o}), 32'b00);
        scan_dr(4, 32'b1011, 32'b0110, 32'h0);

        scan_ir(5'h10, 5'b00001);
        tick(0, 0);
        chk("dtmcs_sel", 32'({dtmcs_select_o, dmi_select_o}), 32'b10);
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 3; i++) begin
            dtmcs_tdo_i = (i != 1);
            exp_q.push_back(i != 1);
            tick(0, 1);
        end
        #1 trst_ni = 1'b0;
        #1;
        chk("abort_clear", 32'(dmi_clear_o), 32'(1));
        chk("abort_strobes", 32'({capture_o, shift_o, update_o}), 32'b000);
        chk("abort_selects", 32'({dtmcs_select_o, dmi_select_o}), 32'b00);
        chk("abort_tdo_oe", 32'({tdo_oe_o, tdo_o}), 32'b00);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0);
            chk("abort_no_update", 32'(update_o), 32'(0));
        end
        trst_ni = 1'b1;
        tick(1, 0);
        chk("post_abort_tlr", 32'({dmi_clear_o, update_o}), 32'b10);
        tick(0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        mon_en = 1'b0;
        model = RTI;
        for (int i = 0; i < 10000; i++) begin
            tms_i = 1'($urandom_range(0, 1));
            tdi_i = 1'($urandom_range(0, 1));
            dtmcs_tdo_i = 1'($urandom_range(0, 1));
            dmi_tdo_i = 1'($urandom_range(0, 1));
            model = tap_next(model, tms_i);
            @(posedge tck_i); #2;
            chk("walk_strobes", 32'({capture_o, shift_o, update_o, dmi_clear_o}),
                32'({model == CAP_DR, model == SH_DR, model == UPD_DR, model == TLR}));
            @(negedge tck_i); #1;
            chk("walk_tdo_oe", 32'(tdo_oe_o), 32'(model == SH_DR || model == SH_IR));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmi_jtag_soft_tap.md
Name: dmi_jtag_soft_tap

Overview:
- Fabric-independent, fully RTL IEEE 1149.1 TAP controller.
- Drives the DTM's DTMCS and DMI data registers on chip pins instead of through vendor BSCAN primitives.
- Generalises the primitive-based TAP with parametrised IR length, IR opcodes and IDCODE, plus built-in IDCODE and BYPASS registers.
- Sits between the chip JTAG pins and the DTM; the downstream select/capture/shift/update interface is unchanged.

Parameters:
IR_LEN, 5, instruction register width (>=2)
IDCODE_VAL, 32'h0000_0DB3, device ID; bit 0 must be 1 (elaboration assert)
IR_IDCODE, 5'h01, opcode selecting the IDCODE register
IR_DTMCS, 5'h10, opcode selecting DTMCS
IR_DMI, 5'h11, opcode selecting DMI

Ports:
tck_i  in  1  JTAG clock; the only clock
trst_ni  in  1  asynchronous active-low reset
tms_i  in  1  test mode select, sampled on rising tck_i
tdi_i  in  1  serial data in, sampled on rising tck_i
tdo_o  out  1  serial data out, updated on falling tck_i
tdo_oe_o  out  1  tdo output enable, updated on falling tck_i
tdi_o  out  1  tdi_i forwarded to DTM registers
capture_o  out  1  fsm in CAPTURE_DR
shift_o  out  1  fsm in SHIFT_DR
update_o  out  1  fsm in UPDATE_DR
dmi_clear_o  out  1  fsm in TEST_LOGIC_RESET
dtmcs_select_o  out  1  IR == IR_DTMCS
dtmcs_tdo_i  in  1  DTMCS serial out
dmi_select_o  out  1  IR == IR_DMI
dmi_tdo_i  in  1  DMI serial out

Behaviour:
- FSM has the 16 standard states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, and the same set for IR. Transitions follow the 1149.1 TMS table on rising tck_i.
- trst_ni low, asynchronously:
  - fsm=TLR, IR=IR_IDCODE, bypass=0, IDCODE shifter=IDCODE_VAL.
  - tdo_o=0, tdo_oe_o=0, dmi_clear_o=1.
  - capture/shift/update=0, dtmcs_select_o=0, dmi_select_o=0.
- TMS high for 5 consecutive rising edges reaches TLR from any state. TLR also reloads IR=IR_IDCODE synchronously.
- IR path:
  - CAP_IR loads ir_shift = {IR_LEN-2 zeros, 2'b01}.
  - SH_IR shifts right: MSB<=tdi_i, LSB goes to tdo.
  - UPD_IR copies ir_shift to IR on the rising edge leaving UPD_IR, so the new IR is visible 1 cycle after UPD_IR.
- DR path, by current IR:
  - IDCODE: CAP_DR loads IDCODE_VAL; SH_DR shifts right with tdi_i in at the MSB.
  - BYPASS (any opcode not listed, including all-ones): CAP_DR loads 0; SH_DR loads tdi_i; 1-bit delay.
  - DTMCS/DMI: the local TAP holds no state. The selected register reacts to capture_o/shift_o/update_o with dtmcs_select_o/dmi_select_o.
- capture_o/shift_o/update_o/dmi_clear_o are combinational decodes of the registered state. Selects are a combinational decode of IR. All are glitch-free relative to rising tck_i.
- TDO mux, registered on falling tck_i:
  - SH_IR: ir_shift[0].
  - SH_DR: IDCODE bit0, bypass bit, dtmcs_tdo_i or dmi_tdo_i, per IR.
  - Otherwise tdo_o holds and tdo_oe_o=0.
  - tdo_oe_o=1 exactly while the fsm is in SH_IR or SH_DR.
- An IR_LEN mismatch from the host is not detected; any shifted value is legal.
- trst_ni asserted mid-shift aborts the shift. IR and all registers return to reset values; no update pulse is emitted.

Decomposition:
- Package dm_jtag_pkg holds:
  - tap_state_e, a 4-bit enum of the 16 states;
  - default opcode localparams;
  - the IR capture pattern constant.
- Sub-module dmi_jtag_tap_fsm: tck_i, trst_ni, tms_i -> state. Pure next-state logic plus the state register.
- The top holds the IR, IDCODE and bypass registers, the decodes, and the negedge TDO stage.

Test Plan:
- Reset, then TMS 0,1,0,0 to SH_DR, then 32 shifts with tdi=0 -> tdo LSB-first = 32'h0000_0DB3; tdo_oe_o=1 only during the shifts.
- From SH_DR, TMS=1 x5 -> TLR, dmi_clear_o=1, IR reads back IR_IDCODE.
- Write IR=5'h11 -> dmi_select_o=1 one cycle after UPD_IR. Then a DR scan pulses capture_o 1 cycle, holds shift_o N cycles and pulses update_o 1 cycle; tdo mirrors dmi_tdo_i delayed half a tck.
- IR scan with tdi=5'h1F -> captured IR out = 5'b00001. Following DR scan with tdi pattern 1011 -> tdo 0,1,1,0 (1-bit bypass delay, leading 0).
- IR=5'h10, drop trst_ni mid SH_DR -> immediate TLR, all selects 0, tdo_oe_o=0, no update_o pulse.
- Random TMS walk of 10k cycles against a reference model of the 16-state table -> state and strobes match every cycle.
